// File: rtl/count_run_arbiter.sv
// count_run_arbiter
// Round-robin controller that lends one shared up/down counter to NREQ
// requesters. Each granted run clears the counter, then steps it in the
// latched direction for the latched number of clocks. A done pulse is sent
// to the requester at the end of the run, qualified by 'aborted'.
module count_run_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       dir,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  aborted,
    output logic                  busy,
    output logic                  cnt_clr,
    output logic                  cnt_en,
    output logic                  cnt_up
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     winner_q, winner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  len_q, len_d;
    logic [WIDTH-1:0]  step_q, step_d;
    logic              abort_q, abort_d;

    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              busy_q, busy_d;
    logic              clr_q, clr_d;
    logic              en_q, en_d;
    logic              up_q, up_d;

    // State, run context and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            rr_q      <= '0;
            dir_q     <= 1'b0;
            len_q     <= '0;
            step_q    <= '0;
            abort_q   <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            clr_q     <= 1'b0;
            en_q      <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            rr_q      <= rr_d;
            dir_q     <= dir_d;
            len_q     <= len_d;
            step_q    <= step_d;
            abort_q   <= abort_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            clr_q     <= clr_d;
            en_q      <= en_d;
            up_q      <= up_d;
        end
    end

    // Next-state logic: round-robin pick in IDLE, step countdown and abort in RUN.
    always_comb begin
        int  sel;
        int  idx;
        logic found;
        state_d  = state_q;
        winner_d = winner_q;
        rr_d     = rr_q;
        dir_d    = dir_q;
        len_d    = len_q;
        step_d   = step_q;
        abort_d  = abort_q;
        sel      = 0;
        idx      = 0;
        found    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    for (int i = 0; i < NREQ; i++) begin
                        idx = (int'(rr_q) + i) % NREQ;
                        if (!found && req[idx]) begin
                            found = 1'b1;
                            sel   = idx;
                        end
                    end
                    winner_d = IW'(sel);
                    dir_d    = dir[sel];
                    len_d    = len[sel*WIDTH +: WIDTH];
                    abort_d  = 1'b0;
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    step_d  = len_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_d = step_q - WIDTH'(1);
                if (!req[winner_q]) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else if (step_q == WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (winner_q == IW'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = winner_q + IW'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs line up with it.
    always_comb begin
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        busy_d    = 1'b0;
        clr_d     = 1'b0;
        en_d      = 1'b0;
        up_d      = 1'b0;
        case (state_d)
            CLEAR: begin
                gnt_d[winner_d] = 1'b1;
                clr_d           = 1'b1;
                up_d            = dir_d;
                busy_d          = 1'b1;
            end
            RUN: begin
                gnt_d[winner_d] = 1'b1;
                en_d            = 1'b1;
                up_d            = dir_d;
                busy_d          = 1'b1;
            end
            DONE: begin
                done_d[winner_d] = 1'b1;
                aborted_d        = abort_d;
                busy_d           = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign busy    = busy_q;
    assign cnt_clr = clr_q;
    assign cnt_en  = en_q;
    assign cnt_up  = up_q;

endmodule

// File: tb/tb_count_run_arbiter.sv
// tb_count_run_arbiter
// Directed bench for count_run_arbiter with a behavioural 4-bit counter
// attached to the clear/enable/direction strobes.
module tb_count_run_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  dir;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        aborted;
    logic        busy;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_up;

    logic [3:0]  cntModel = 4'd0;
    int          checks   = 0;
    int          failures = 0;

    count_run_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .dir     (dir),
        .len     (len),
        .gnt     (gnt),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .cnt_up  (cnt_up)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Shared counter driven by the arbiter's strobes.
    always @(posedge clk) begin
        if (cnt_clr) begin
            cntModel <= 4'd0;
        end else if (cnt_en) begin
            cntModel <= cnt_up ? cntModel + 4'd1 : cntModel - 4'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic [15:0] l);
        req = r;
        dir = d;
        len = l;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] eGnt, input logic [3:0] eDone,
                               input logic eAb, input logic eBusy, input logic eClr,
                               input logic eEn, input logic eUp, input logic upCare);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {gnt, done, aborted, busy, cnt_clr, cnt_en, (upCare ? cnt_up : 1'b0)};
        exp = {eGnt, eDone, eAb, eBusy, eClr, eEn, (upCare ? eUp : 1'b0)};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b (gnt,done,ab,busy,clr,en,up)", tag, obs, exp);
        end
    endtask

    task automatic checkCounter(input string tag, input logic [3:0] expCnt);
        checks++;
        assert (cntModel === expCnt) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, cntModel, expCnt);
        end
    endtask

    // Directed sequence covering every test-plan scenario.
    initial begin
        logic [3:0] downSeq [3];
        downSeq[0] = 4'd0;
        downSeq[1] = 4'd15;
        downSeq[2] = 4'd14;

        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        tick();
        tick();
        checkOutput("reset_state", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        tick();
        checkOutput("idle_no_req", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        $display("[TB] single up run, requester 0, len 5");
        applyStimulus(4'b0001, 4'b0001, 16'h0005);
        tick();
        checkOutput("up_clear", 4'b0001, 4'b0000, 0, 1, 1, 0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("up_run", 4'b0001, 4'b0000, 0, 1, 0, 1, 1, 1);
        end
        tick();
        checkOutput("up_done", 4'b0000, 4'b0001, 0, 1, 0, 0, 0, 0);
        checkCounter("up_count", 4'd5);
        applyStimulus(4'b0000, 4'b0001, 16'h0005);
        tick();
        checkOutput("up_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        $display("[TB] down run with wrap, requester 1, len 3");
        applyStimulus(4'b0010, 4'b0000, 16'h0030);
        tick();
        checkOutput("down_clear", 4'b0010, 4'b0000, 0, 1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("down_run", 4'b0010, 4'b0000, 0, 1, 0, 1, 0, 1);
            checkCounter("down_cnt", downSeq[k]);
        end
        tick();
        checkOutput("down_done", 4'b0000, 4'b0010, 0, 1, 0, 0, 0, 0);
        checkCounter("down_final", 4'd13);
        applyStimulus(4'b0000, 4'b0000, 16'h0030);
        tick();

        $display("[TB] zero length run, requester 2");
        applyStimulus(4'b0100, 4'b0000, 16'hF0FF);
        tick();
        checkOutput("zero_clear", 4'b0100, 4'b0000, 0, 1, 1, 0, 0, 1);
        tick();
        checkOutput("zero_done", 4'b0000, 4'b0100, 0, 1, 0, 0, 0, 0);
        checkCounter("zero_count", 4'd0);
        applyStimulus(4'b0000, 4'b0000, 16'hF0FF);
        tick();
        checkOutput("zero_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        $display("[TB] reset during run, requester 0, len 9");
        applyStimulus(4'b0001, 4'b0001, 16'h0009);
        tick();
        checkOutput("rst_clear", 4'b0001, 4'b0000, 0, 1, 1, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("rst_run", 4'b0001, 4'b0000, 0, 1, 0, 1, 1, 1);
        end
        reset = 1'b1;
        tick();
        checkOutput("rst_midrun", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        applyStimulus(4'b1011, 4'b1111, 16'h1021);
        tick();
        checkOutput("rst_fresh_clear", 4'b0001, 4'b0000, 0, 1, 1, 0, 1, 1);

        $display("[TB] round robin over requesters 0,1,3");
        tick();
        checkOutput("rr0_run", 4'b0001, 4'b0000, 0, 1, 0, 1, 1, 1);
        tick();
        checkOutput("rr0_done", 4'b0000, 4'b0001, 0, 1, 0, 0, 0, 0);
        applyStimulus(4'b1010, 4'b1111, 16'h1021);
        tick();
        checkOutput("rr_gap0", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);
        tick();
        checkOutput("rr1_clear", 4'b0010, 4'b0000, 0, 1, 1, 0, 1, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("rr1_run", 4'b0010, 4'b0000, 0, 1, 0, 1, 1, 1);
        end
        tick();
        checkOutput("rr1_done", 4'b0000, 4'b0010, 0, 1, 0, 0, 0, 0);
        applyStimulus(4'b1001, 4'b1111, 16'h102A);
        tick();
        tick();
        checkOutput("rr3_clear", 4'b1000, 4'b0000, 0, 1, 1, 0, 1, 1);
        tick();
        checkOutput("rr3_run", 4'b1000, 4'b0000, 0, 1, 0, 1, 1, 1);
        tick();
        checkOutput("rr3_done", 4'b0000, 4'b1000, 0, 1, 0, 0, 0, 0);
        applyStimulus(4'b0001, 4'b1111, 16'h102A);
        tick();
        tick();
        checkOutput("rr0_again_clear", 4'b0001, 4'b0000, 0, 1, 1, 0, 1, 1);

        $display("[TB] abort of requester 0 run, len 10");
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("abort_run", 4'b0001, 4'b0000, 0, 1, 0, 1, 1, 1);
        end
        checkCounter("abort_pre", 4'd4);
        applyStimulus(4'b0000, 4'b1111, 16'h102A);
        tick();
        checkOutput("abort_done", 4'b0000, 4'b0001, 1, 1, 0, 0, 0, 0);
        checkCounter("abort_count", 4'd5);
        tick();
        checkOutput("abort_idle", 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_run_arbiter.md
Name: count_run_arbiter

Overview:
Round-robin controller that shares one 4-bit up/down counter between NREQ requesters. Each requester asks for a "count run": clear the counter, then step it up or down for a programmed number of clocks. The block grants one requester at a time and drives the counter's clear, enable and direction inputs. It pulses a per-requester done flag at the end of each run. It sits between the requesting control logic and the shared counter instance.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, width of run-length field and internal step counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NREQ  per-requester run request, level, held until done
dir  input  NREQ  per-requester direction, 1 = up, 0 = down
len  input  NREQ*WIDTH  per-requester run length in counter steps; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, registered
done  output  NREQ  one-cycle completion pulse to the granted requester
aborted  output  1  qualifies done: 1 = run cut short by req drop
busy  output  1  high in every state except IDLE
cnt_clr  output  1  clear strobe to shared counter
cnt_en  output  1  step enable to shared counter
cnt_up  output  1  direction to shared counter, 1 = up

Behaviour:
- Reset is synchronous, active-high, and wins over all other activity, including mid-run.
- On reset: state IDLE, rr pointer = 0, step counter = 0, and every output = 0.
- All outputs are registered and are decoded from state plus latched winner and direction.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If req != 0, pick the first set req bit at or after rr pointer, scanning upward with wrap mod NREQ.
  - Latch the winner index w, dir[w] and len[w].
  - Next state is CLEAR.
  - If req == 0, stay in IDLE.
- CLEAR (exactly 1 cycle):
  - gnt[w] = 1, cnt_clr = 1, cnt_en = 0, cnt_up = latched dir.
  - If latched len == 0, next state is DONE; else next state is RUN with step counter = latched len.
- RUN:
  - gnt[w] = 1, cnt_en = 1, cnt_up = latched dir.
  - Step counter decrements each cycle; RUN lasts exactly len cycles, so the counter receives exactly len enable cycles.
  - Leave for DONE in the cycle the step counter reaches 1.
- Abort: if req[w] is sampled 0 in any RUN cycle, go to DONE next cycle with aborted set.
  - cnt_en is still 1 in the sampling cycle, because outputs are registered.
  - Abort is not possible in CLEAR, since req is only sampled in RUN.
- DONE (exactly 1 cycle):
  - gnt = 0, cnt_en = 0, cnt_clr = 0, done[w] = 1.
  - aborted = 1 if the run was aborted, else 0.
  - rr pointer becomes (w+1) mod NREQ.
  - Next state is IDLE.
- Minimum request-to-grant latency is 1 cycle (IDLE sample to CLEAR).
- Minimum gap between runs is DONE + IDLE: 2 cycles with gnt = 0.
- Changes to req, dir or len from non-granted requesters during a run have no effect.
- dir and len of the winner are latched and ignored after IDLE.
- Counter wrap-around (15->0 up, 0->15 down) belongs to the counter; the controller does not track counter value.
- gnt is never multi-hot; at most one done bit is set per cycle.

Test Plan:
- Reset during RUN (req0 len=9, assert reset at 3rd RUN cycle) -> next cycle all outputs 0, rr=0; release reset with req0 still high -> fresh CLEAR after 1 IDLE cycle.
- Single request (req=0001, dir0=1, len0=5) -> 1 CLEAR cycle, 5 cycles cnt_en=1 cnt_up=1, done=0001 aborted=0; attached counter reads 5.
- Down run with wrap (req1, dir1=0, len1=3) -> counter goes 0,15,14,13; done=0010.
- Round robin (req=1011 held; each requester drops req after its done) -> grant order 0,1,3, then 0 again.
- Zero length (req2, len2=0) -> CLEAR then DONE; no cnt_en cycle; done=0100; counter reads 0.
- Abort (req0 len=10, drop req0 after 4 RUN cycles) -> done=0001 with aborted=1; counter shows 5 steps; gnt low in DONE.
